// File: rtl/bitsim_pe_pkg.sv
// Shared widths and FSM state type for the bit-sparse position decoder path.
package bitsim_pe_pkg;
  localparam int POS_W  = 3;
  localparam int MASK_W = 8;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;
endpackage

// File: rtl/p_decoder_3to8.sv
// Combinational 3-bit position to 8-bit one-hot; MSB_FIRST=1 puts pos 0 on bit 7.
module p_decoder_3to8
  import bitsim_pe_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic [POS_W-1:0]  pos,
  output logic [MASK_W-1:0] onehot
);
  logic [POS_W-1:0] idx;

  assign idx    = MSB_FIRST ? POS_W'(MASK_W - 1) - pos : pos;
  assign onehot = MASK_W'(1) << idx;
endmodule

// File: rtl/p_decoder_3to8_seq.sv
// Rebuilds an 8-bit mask and popcount from a stream of leading-one positions.
// Optional protocol checks are compiled in with `define P_DECODER_ERR_CHK_EN.
module p_decoder_3to8_seq
  import bitsim_pe_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [POS_W-1:0]  in_pos,
  input  logic              in_is_zero,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MASK_W-1:0] out_mask,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_err
);
  state_e            state_q, state_d;
  logic [MASK_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [MASK_W-1:0] out_mask_q, out_mask_d;
  logic [CNT_W-1:0]  out_count_q, out_count_d;

  logic [MASK_W-1:0] pos_oh, beat_bits, acc_nxt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              accept, load_out, clr_word;

  p_decoder_3to8 #(.MSB_FIRST(MSB_FIRST)) u_dec (
    .pos    (in_pos),
    .onehot (pos_oh)
  );

  assign in_ready  = (state_q != HOLD);
  assign out_valid = (state_q == HOLD);
  assign accept    = in_valid && in_ready;
  assign load_out  = accept && in_last;
  assign clr_word  = (state_q == HOLD) && out_ready;

  // Duplicate positions leave the count alone: only freshly set bits count.
  assign beat_bits = in_is_zero ? '0 : pos_oh;
  assign acc_nxt   = acc_q | beat_bits;
  assign cnt_nxt   = cnt_q + CNT_W'(|(beat_bits & ~acc_q));

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_mask_d  = out_mask_q;
    out_count_d = out_count_q;
    case (state_q)
      IDLE, ACCUM: begin
        if (accept) begin
          acc_d   = acc_nxt;
          cnt_d   = cnt_nxt;
          state_d = in_last ? HOLD : ACCUM;
          if (in_last) begin
            out_mask_d  = acc_nxt;
            out_count_d = cnt_nxt;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_mask_q  <= '0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_mask_q  <= out_mask_d;
      out_count_q <= out_count_d;
    end
  end

  assign out_mask  = out_mask_q;
  assign out_count = out_count_q;

`ifdef P_DECODER_ERR_CHK_EN
  logic [POS_W-1:0] prev_pos_q, prev_pos_d;
  logic             prev_vld_q, prev_vld_d;
  logic             err_q, err_d;
  logic             out_err_q, out_err_d;
  logic             beat_err, err_nxt;

  // Order is only checked against a preceding non-zero beat; a zero beat
  // mid-word is already flagged on its own.
  assign beat_err = (in_is_zero && !in_last) ||
                    (in_is_zero && state_q == ACCUM) ||
                    (!in_is_zero && prev_vld_q && in_pos <= prev_pos_q);
  assign err_nxt  = err_q || beat_err;

  always_comb begin
    prev_pos_d = prev_pos_q;
    prev_vld_d = prev_vld_q;
    err_d      = err_q;
    out_err_d  = out_err_q;
    if (accept) begin
      prev_pos_d = in_pos;
      prev_vld_d = !in_is_zero;
      err_d      = err_nxt;
      if (in_last) out_err_d = err_nxt;
    end else if (clr_word) begin
      prev_vld_d = 1'b0;
      err_d      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_pos_q <= '0;
      prev_vld_q <= 1'b0;
      err_q      <= 1'b0;
      out_err_q  <= 1'b0;
    end else begin
      prev_pos_q <= prev_pos_d;
      prev_vld_q <= prev_vld_d;
      err_q      <= err_d;
      out_err_q  <= out_err_d;
    end
  end

  assign out_err = out_err_q;
`else
  logic unused_chk;
  assign unused_chk = load_out ^ clr_word;
  assign out_err    = 1'b0;
`endif
endmodule

// File: tb/tb_p_decoder_3to8_seq.sv
// Directed and randomized checks of the position-stream decoder against a word-level model.
module tb_p_decoder_3to8_seq;
  localparam bit MSB_FIRST = 1'b1;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid, in_ready, in_is_zero, in_last;
  logic [2:0] in_pos;
  logic       out_valid, out_ready, out_err;
  logic [7:0] out_mask;
  logic [3:0] out_count;

  int n_chk  = 0;
  int n_fail = 0;

  p_decoder_3to8_seq #(.MSB_FIRST(MSB_FIRST)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pos     (in_pos),
    .in_is_zero (in_is_zero),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_mask   (out_mask),
    .out_count  (out_count),
    .out_err    (out_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Word-level reference: bit index from the position mapping, popcount of the mask.
  function automatic logic [7:0] bit_of(input int p);
    int idx;
    idx = MSB_FIRST ? 7 - p : p;
    return 8'(1 << idx);
  endfunction

  function automatic logic model_err(input int ps[$], input bit zs[$]);
    logic e = 1'b0;
    for (int i = 0; i < ps.size(); i++) begin
      if (zs[i] && i != ps.size() - 1) e = 1'b1;
      if (zs[i] && i > 0) e = 1'b1;
      if (!zs[i] && i > 0 && !zs[i-1] && ps[i] <= ps[i-1]) e = 1'b1;
    end
`ifdef P_DECODER_ERR_CHK_EN
    return e;
`else
    return 1'b0 & e;
`endif
  endfunction

  task automatic send_beat(input int p, input bit z, input bit l, output logic rdy0);
    int cyc = 0;
    @(negedge clk);
    in_valid = 1'b1; in_pos = 3'(p); in_is_zero = z; in_last = l;
    rdy0 = in_ready;
    while (!in_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    if (!in_ready) chk("send_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic recv(input string tag, input logic [7:0] em, input logic [3:0] ec, input logic ee);
    int cyc = 0;
    while (!out_valid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_mask"},  32'(out_mask),  32'(em));
    chk({tag, "_count"}, 32'(out_count), 32'(ec));
    chk({tag, "_err"},   32'(out_err),   32'(ee));
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic run_word(input string tag, input int ps[$], input bit zs[$]);
    logic [7:0] m = '0;
    logic r;
    for (int i = 0; i < ps.size(); i++) begin
      if (!zs[i]) m |= bit_of(ps[i]);
      send_beat(ps[i], zs[i], i == ps.size() - 1, r);
    end
    recv(tag, m, 4'($countones(m)), model_err(ps, zs));
  endtask

  initial begin
    logic r;
    logic [7:0] m;
    int ps[$];
    bit zs[$];
    reset = 1'b1; in_valid = 1'b0; in_pos = '0; in_is_zero = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mask", 32'(out_mask), 32'd0);
    chk("rst_count", 32'(out_count), 32'd0);
    chk("rst_err", 32'(out_err), 32'd0);

    // Single pos 0: valid right after the accepting edge.
    send_beat(0, 1'b0, 1'b1, r);
    chk("lat_valid", 32'(out_valid), 32'd1);
    chk("lat_in_ready", 32'(in_ready), 32'd0);
    recv("pos0", 8'h80, 4'd1, 1'b0);

    send_beat(1, 1'b0, 1'b0, r); chk("rdy_b0", 32'(r), 32'd1);
    send_beat(4, 1'b0, 1'b0, r); chk("rdy_b1", 32'(r), 32'd1);
    send_beat(7, 1'b0, 1'b1, r); chk("rdy_b2", 32'(r), 32'd1);
    recv("w49", 8'h49, 4'd3, 1'b0);

    send_beat(0, 1'b1, 1'b1, r);
    recv("zero", 8'h00, 4'd0, 1'b0);

    // Backpressure with a pending beat.
    send_beat(1, 1'b0, 1'b0, r);
    send_beat(4, 1'b0, 1'b0, r);
    send_beat(7, 1'b0, 1'b1, r);
    @(negedge clk);
    in_valid = 1'b1; in_pos = 3'd0; in_is_zero = 1'b0; in_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_mask", 32'(out_mask), 32'h49);
      chk("bp_count", 32'(out_count), 32'd3);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("bp_after_hs_ready", 32'(in_ready), 32'd1);
    chk("bp_after_hs_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    recv("bp_pending", 8'h80, 4'd1, 1'b0);

    ps = '{5, 2}; zs = '{1'b0, 1'b0};
    run_word("order", ps, zs);
    ps = '{3, 3}; zs = '{1'b0, 1'b0};
    run_word("dup", ps, zs);

    // Reset mid-word discards the partial word.
    send_beat(3, 1'b0, 1'b0, r);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    chk("midrst_ready", 32'(in_ready), 32'd1);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    send_beat(6, 1'b0, 1'b1, r);
    recv("midrst", 8'h02, 4'd1, 1'b0);

    for (int w = 0; w < 60; w++) begin
      ps = {}; zs = {};
      if ($urandom_range(0, 2) == 0) begin
        int n = $urandom_range(1, 4);
        for (int i = 0; i < n; i++) begin
          ps.push_back($urandom_range(0, 7));
          zs.push_back($urandom_range(0, 9) == 0);
        end
      end else begin
        m = 8'($urandom);
        for (int p = 0; p < 8; p++)
          if ((m & bit_of(p)) != 0) begin ps.push_back(p); zs.push_back(1'b0); end
        if (ps.size() == 0) begin ps.push_back($urandom_range(0, 7)); zs.push_back(1'b1); end
      end
      run_word("rand", ps, zs);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/p_decoder_3to8_seq.md
# p_decoder_3to8_seq

Sequential bit-position decoder: the receive-side counterpart of the 8-to-3 priority encoder. It consumes a stream of 3-bit leading-one positions, one per beat, and rebuilds the original 8-bit bitmask and its popcount. The reconstructed word is presented on a valid/ready output port. It sits at the consumer end of the bit-sparse operand path, where encoded essential-bit positions are turned back into masks for verification and reconstruction.

## Interface
- MSB_FIRST, default 1: index convention. With 1, pos 0 maps to bit 7 and pos 7 maps to bit 0, matching the encoder. With 0, pos k maps to bit k.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts a beat.
- in_pos  in  3  bit position of one set bit.
- in_is_zero  in  1  beat marks an all-zero word; in_pos is ignored.
- in_last  in  1  final beat of the current word.
- out_valid  out  1  reconstructed word available.
- out_ready  in  1  downstream accepts the word.
- out_mask  out  8  reconstructed bitmask.
- out_count  out  4  number of set bits in out_mask, 0..8.
- out_err  out  1  protocol error detected in this word.

## Operation
- A beat is accepted when in_valid && in_ready at a posedge.
- FSM states:
  - IDLE: no word in progress; in_ready=1.
  - ACCUM: at least one non-last beat accepted; in_ready=1.
  - HOLD: word complete; out_valid=1, in_ready=0.
- Transitions:
  - IDLE→ACCUM on an accepted beat with in_last=0.
  - IDLE→HOLD or ACCUM→HOLD on an accepted beat with in_last=1.
  - HOLD→IDLE on out_valid && out_ready.
- Accepted non-zero beat: mask |= onehot(pos). count increments only if that bit was previously clear.
- Beat with in_is_zero=1: no mask bit set.
- Duplicate position: mask unchanged, count unchanged.
- On entering IDLE from HOLD, the accumulator clears to 0 and the error flag clears.
- Stored outputs out_mask, out_count and out_err change only on HOLD entry or reset.
- Reset values: in_ready=1 after reset; out_valid=0, out_mask=0, out_count=0, out_err=0, state IDLE.
- Reset mid-word discards the partial mask, count and error flag.
- Error conditions (only with the error-check feature compiled in):
  - in_is_zero=1 with in_last=0.
  - in_is_zero=1 on a non-first beat.
  - Position not strictly increasing relative to the previous beat of the same word (encoder emission order).
- An error is sticky for the word and reported on out_err together with the word. The mask is still accumulated.

## Timing
- Output latency: out_valid rises the cycle after the posedge that accepts the last beat.
- Throughput: one N-beat word per N+1 cycles when out_ready is held high.
- in_ready is a pure function of state; there is no combinational path from out_ready.
- While out_valid && !out_ready: out_mask, out_count and out_err stay stable and in_ready stays 0.
- in_valid with in_ready=0 has no effect. The sender must hold the beat.

## Configuration
- P_DECODER_ERR_CHK_EN defined: previous-position register, order/zero checks and sticky error flag are present; out_err behaves as specified.
- P_DECODER_ERR_CHK_EN undefined: checks are removed and out_err is tied 0. Mask and count behaviour are identical.

## Structure
- Shared package bitsim_pe_pkg holds:
  - POS_W=3, MASK_W=8, CNT_W=4.
  - The FSM state enum typedef (IDLE, ACCUM, HOLD).
- One combinational sub-module, p_decoder_3to8: 3-bit position to 8-bit one-hot under the MSB_FIRST mapping. It is instantiated once.

## Test plan
- Pos 0, last, MSB_FIRST=1 -> out_mask=0x80, out_count=1, out_err=0, out_valid one cycle after acceptance.
- Pos 1, 4, 7 (last on 7) -> out_mask=0x49, out_count=3, out_err=0. in_ready stays high for all three beats.
- in_is_zero=1, last -> out_mask=0x00, out_count=0, out_err=0.
- Word 0x49 with out_ready low for 3 cycles:
  - out_mask is held and in_ready=0 throughout.
  - A pending in_valid beat is accepted only after the handshake cycle.
- Pos 5 then pos 2 (last), error check enabled -> out_mask=0x24, out_count=2, out_err=1. With the macro undefined, out_err=0.
- Pos 3 accepted, reset asserted one cycle, then pos 6 last -> out_mask=0x02, out_count=1. No trace of pos 3 remains.
